// File: rtl/sudoku_move_ctrl.sv
// Move sequencer for the 4x4 Sudoku core: debounces the buttons, decodes the switches and
// validates each move against its row, column and 2x2 box over a 4-cycle scan.
module sudoku_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enter,
    input  logic        clear,
    input  logic        new_game,
    input  logic [3:0]  row_sel,
    input  logic [3:0]  col_sel,
    input  logic [3:0]  num_in,
    input  logic [31:0] puzzle_vals,
    input  logic [15:0] puzzle_mask,
    output logic [31:0] cell_vals,
    output logic [15:0] filled,
    output logic [15:0] fixed_mask,
    output logic [1:0]  cursor_row,
    output logic [1:0]  cursor_col,
    output logic        error_flag,
    output logic        win_flag,
    output logic        busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, WINCHK} state_t;

    // Button index: 0 = enter, 1 = clear, 2 = new_game.
    logic [2:0]    btn_raw, btn_s1, btn_s2, btn_stable, btn_prev, btn_pulse;
    logic [CW-1:0] db_cnt [3];

    assign btn_raw = {new_game, clear, enter};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make the synchronizer collapse to one stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            btn_stable <= '0;
            btn_prev   <= '0;
            for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            btn_prev <= btn_stable;
            for (int b = 0; b < 3; b++) begin
                if (btn_s2[b] == btn_stable[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CNT_MAX) begin
                    btn_stable[b] <= btn_s2[b];
                    db_cnt[b]     <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + CW'(1);
                end
            end
        end
    end

    assign btn_pulse = btn_stable & ~btn_prev;

    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++)
            if (v[k]) idx = 2'(k);
        return idx;
    endfunction

    logic       sel_valid, num_valid;
    logic [3:0] sel_cell;

    assign sel_valid = $onehot(row_sel) && $onehot(col_sel);
    assign num_valid = $onehot(num_in);
    assign sel_cell  = {enc4(row_sel), enc4(col_sel)};

    state_t     state;
    logic [1:0] scan_idx;
    logic [3:0] tgt_cell;
    logic [1:0] tgt_digit;
    logic       conflict;
    logic [3:0] peer [3];
    logic       hit;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        peer[0] = {tgt_cell[3:2], scan_idx};
        peer[1] = {scan_idx, tgt_cell[1:0]};
        peer[2] = {tgt_cell[3], scan_idx[1], tgt_cell[1], scan_idx[0]};
        hit     = 1'b0;
        for (int p = 0; p < 3; p++)
            if (filled[peer[p]] && cell_vals[{peer[p], 1'b0} +: 2] == tgt_digit &&
                peer[p] != tgt_cell)
                hit = 1'b1;
    end

    // NOTE: the grid is plain flops, so it is reset along with the rest of the state;
    // the renderer must see an empty board after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cell_vals  <= '0;
            filled     <= '0;
            fixed_mask <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            error_flag <= 1'b0;
            win_flag   <= 1'b0;
            busy       <= 1'b0;
            scan_idx   <= '0;
            tgt_cell   <= '0;
            tgt_digit  <= '0;
            conflict   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        cursor_row <= sel_cell[3:2];
                        cursor_col <= sel_cell[1:0];
                    end
                    if (btn_pulse[2]) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end else if (btn_pulse[0]) begin
                        // A finished board ignores further moves until new_game.
                        if (!win_flag) begin
                            if (!sel_valid || !num_valid || fixed_mask[sel_cell]) begin
                                error_flag <= 1'b1;
                            end else begin
                                tgt_cell  <= sel_cell;
                                tgt_digit <= enc4(num_in);
                                conflict  <= 1'b0;
                                scan_idx  <= 2'd0;
                                state     <= CHECK;
                                busy      <= 1'b1;
                            end
                        end
                    end else if (btn_pulse[1]) begin
                        if (!win_flag) begin
                            if (!sel_valid || fixed_mask[sel_cell]) begin
                                error_flag <= 1'b1;
                            end else begin
                                filled[sel_cell] <= 1'b0;
                                error_flag       <= 1'b0;
                            end
                        end
                    end
                end
                LOAD: begin
                    cell_vals  <= puzzle_vals;
                    filled     <= puzzle_mask;
                    fixed_mask <= puzzle_mask;
                    error_flag <= 1'b0;
                    win_flag   <= 1'b0;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                CHECK: begin
                    conflict <= conflict | hit;
                    scan_idx <= scan_idx + 2'd1;
                    if (scan_idx == 2'd3) state <= COMMIT;
                end
                COMMIT: begin
                    if (conflict) begin
                        error_flag <= 1'b1;
                    end else begin
                        cell_vals[{tgt_cell, 1'b0} +: 2] <= tgt_digit;
                        filled[tgt_cell]                 <= 1'b1;
                        error_flag                       <= 1'b0;
                    end
                    state <= WINCHK;
                end
                WINCHK: begin
                    win_flag <= &filled;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sudoku_move_ctrl.sv
// Directed bench for sudoku_move_ctrl: vector table for single operations plus
// hand-written sequences for move timing, debounce, win and reset-abort cases.
module tb_sudoku_move_ctrl;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset, enter, clear, new_game;
    logic [3:0]  row_sel, col_sel, num_in;
    logic [31:0] puzzle_vals;
    logic [15:0] puzzle_mask;
    logic [31:0] cell_vals;
    logic [15:0] filled, fixed_mask;
    logic [1:0]  cursor_row, cursor_col;
    logic        error_flag, win_flag, busy;

    always #5 clk = ~clk;

    sudoku_move_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .enter(enter), .clear(clear), .new_game(new_game),
        .row_sel(row_sel), .col_sel(col_sel), .num_in(num_in),
        .puzzle_vals(puzzle_vals), .puzzle_mask(puzzle_mask),
        .cell_vals(cell_vals), .filled(filled), .fixed_mask(fixed_mask),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .error_flag(error_flag), .win_flag(win_flag), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef enum int {B_ENTER, B_CLEAR, B_NEW} btn_e;

    typedef struct {
        string       name;
        btn_e        btn;
        logic [3:0]  rs, cs, num;
        logic [15:0] exp_filled;
        logic [31:0] exp_vals;
        logic        exp_err, exp_win;
        int          exp_busy;
    } vec_t;

    vec_t vecs [16];

    task automatic set_btn(input btn_e b, input logic v);
        case (b)
            B_ENTER: enter    = v;
            B_CLEAR: clear    = v;
            default: new_game = v;
        endcase
    endtask

    // Press, hold long enough to pass the debouncer, release, then compare.
    task automatic run_vec(input vec_t v);
        int nb = 0;
        row_sel = v.rs; col_sel = v.cs; num_in = v.num;
        repeat (2) @(negedge clk);
        set_btn(v.btn, 1'b1);
        repeat (20) begin @(negedge clk); nb += int'(busy); end
        set_btn(v.btn, 1'b0);
        repeat (10) begin @(negedge clk); nb += int'(busy); end
        check({v.name, " filled"}, 32'(filled), 32'(v.exp_filled));
        check({v.name, " cell_vals"}, cell_vals, v.exp_vals);
        check({v.name, " error_flag"}, 32'(error_flag), 32'(v.exp_err));
        check({v.name, " win_flag"}, 32'(win_flag), 32'(v.exp_win));
        check({v.name, " busy_cycles"}, 32'(nb), 32'(v.exp_busy));
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (busy !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({name, " busy_rise"}, 32'(busy), 32'd1);
    endtask

    task automatic release_all();
        enter = 1'b0; clear = 1'b0; new_game = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    int          sol [16] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};
    logic [31:0] sol_vals;
    int          nb;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enter = 1'b0; clear = 1'b0; new_game = 1'b0;
        row_sel = 4'b0000; col_sel = 4'b0000; num_in = 4'b0000;
        puzzle_mask = 16'h8421; puzzle_vals = 32'h0030_0C00;
        for (int i = 0; i < 16; i++) sol_vals[2*i +: 2] = 2'(sol[i] - 1);

        repeat (3) @(negedge clk);
        check("rst cell_vals", cell_vals, 32'h0);
        check("rst filled", 32'(filled), 32'h0);
        check("rst fixed_mask", 32'(fixed_mask), 32'h0);
        check("rst cursor", 32'({cursor_row, cursor_col}), 32'h0);
        check("rst flags", 32'({error_flag, win_flag, busy}), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // new_game: busy for exactly one cycle, loaded state visible the cycle after.
        new_game = 1'b1;
        wait_busy("ng");
        @(negedge clk);
        check("ng busy_one_cycle", 32'(busy), 32'h0);
        check("ng filled", 32'(filled), 32'h8421);
        check("ng fixed_mask", 32'(fixed_mask), 32'h8421);
        check("ng cell_vals", cell_vals, 32'h0030_0C00);
        check("ng flags", 32'({error_flag, win_flag}), 32'h0);
        release_all();

        // Cursor tracks valid switches one cycle later and holds on invalid ones.
        row_sel = 4'b0100; col_sel = 4'b1000;
        @(negedge clk);
        check("cursor valid", 32'({cursor_row, cursor_col}), 32'({2'd2, 2'd3}));
        row_sel = 4'b0011;
        @(negedge clk);
        check("cursor hold", 32'({cursor_row, cursor_col}), 32'({2'd2, 2'd3}));

        // Move timing: digit 2 at (0,1), cycle numbering from the enter pulse.
        row_sel = 4'b0001; col_sel = 4'b0010; num_in = 4'b0010;
        repeat (2) @(negedge clk);
        enter = 1'b1;
        wait_busy("mv");
        nb = 1;
        for (int j = 2; j <= 6; j++) begin
            @(negedge clk);
            nb += int'(busy);
            if (j == 5) check("mv filled_before_commit", 32'(filled), 32'h8421);
        end
        check("mv busy_cycles", 32'(nb), 32'd6);
        check("mv filled", 32'(filled), 32'h8423);
        check("mv cell_vals", cell_vals, 32'h0030_0C04);
        check("mv error_flag", 32'(error_flag), 32'h0);
        @(negedge clk);
        check("mv busy_done", 32'(busy), 32'h0);
        release_all();

        // A 3-cycle bounce on enter must not produce a move.
        row_sel = 4'b0001; col_sel = 4'b0100; num_in = 4'b0100;
        repeat (2) @(negedge clk);
        enter = 1'b1;
        repeat (3) @(negedge clk);
        enter = 1'b0;
        nb = 0;
        repeat (12) begin @(negedge clk); nb += int'(busy); end
        check("bounce busy", 32'(nb), 32'h0);
        check("bounce filled", 32'(filled), 32'h8423);

        // Table: only (0,0) given as digit 1.
        puzzle_mask = 16'h0001; puzzle_vals = 32'h0;
        vecs[0]  = '{"ng_load",      B_NEW,   4'b0001, 4'b0001, 4'b0001, 16'h0001, 32'h0,         1'b0, 1'b0, 1};
        vecs[1]  = '{"row_conflict", B_ENTER, 4'b0001, 4'b1000, 4'b0001, 16'h0001, 32'h0,         1'b1, 1'b0, 6};
        vecs[2]  = '{"col_conflict", B_ENTER, 4'b1000, 4'b0001, 4'b0001, 16'h0001, 32'h0,         1'b1, 1'b0, 6};
        vecs[3]  = '{"box_conflict", B_ENTER, 4'b0010, 4'b0010, 4'b0001, 16'h0001, 32'h0,         1'b1, 1'b0, 6};
        vecs[4]  = '{"clear_ok",     B_CLEAR, 4'b0001, 4'b0010, 4'b0001, 16'h0001, 32'h0,         1'b0, 1'b0, 0};
        vecs[5]  = '{"enter_11_d2",  B_ENTER, 4'b0010, 4'b0010, 4'b0010, 16'h0021, 32'h0000_0400, 1'b0, 1'b0, 6};
        vecs[6]  = '{"enter_fixed",  B_ENTER, 4'b0001, 4'b0001, 4'b0010, 16'h0021, 32'h0000_0400, 1'b1, 1'b0, 0};
        vecs[7]  = '{"clear_fixed",  B_CLEAR, 4'b0001, 4'b0001, 4'b0010, 16'h0021, 32'h0000_0400, 1'b1, 1'b0, 0};
        vecs[8]  = '{"enter_badsel", B_ENTER, 4'b0011, 4'b0001, 4'b0100, 16'h0021, 32'h0000_0400, 1'b1, 1'b0, 0};
        vecs[9]  = '{"clear_11",     B_CLEAR, 4'b0010, 4'b0010, 4'b0100, 16'h0001, 32'h0000_0400, 1'b0, 1'b0, 0};
        vecs[10] = '{"enter_nodig",  B_ENTER, 4'b0100, 4'b0100, 4'b0000, 16'h0001, 32'h0000_0400, 1'b1, 1'b0, 0};
        vecs[11] = '{"enter_22_d3",  B_ENTER, 4'b0100, 4'b0100, 4'b0100, 16'h0401, 32'h0020_0400, 1'b0, 1'b0, 6};
        vecs[12] = '{"overwrite_d4", B_ENTER, 4'b0100, 4'b0100, 4'b1000, 16'h0401, 32'h0030_0400, 1'b0, 1'b0, 6};
        vecs[13] = '{"same_digit",   B_ENTER, 4'b0100, 4'b0100, 4'b1000, 16'h0401, 32'h0030_0400, 1'b0, 1'b0, 6};
        vecs[14] = '{"unfilled_peer",B_ENTER, 4'b0010, 4'b0001, 4'b0010, 16'h0411, 32'h0030_0500, 1'b0, 1'b0, 6};
        vecs[15] = '{"clear_badcol", B_CLEAR, 4'b0010, 4'b0000, 4'b0010, 16'h0411, 32'h0030_0500, 1'b1, 1'b0, 0};
        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Win: load the solution with (3,3) empty, then fill it.
        puzzle_mask = 16'h7FFF; puzzle_vals = sol_vals;
        run_vec('{"win_load", B_NEW, 4'b1000, 4'b1000, 4'b0001, 16'h7FFF, sol_vals, 1'b0, 1'b0, 1});
        row_sel = 4'b1000; col_sel = 4'b1000; num_in = 4'b0001;
        repeat (2) @(negedge clk);
        enter = 1'b1;
        wait_busy("win");
        repeat (5) @(negedge clk);
        check("win filled_c6", 32'(filled), 32'hFFFF);
        check("win flag_c6", 32'(win_flag), 32'h0);
        @(negedge clk);
        check("win flag_c7", 32'(win_flag), 32'h1);
        check("win busy_c7", 32'(busy), 32'h0);
        release_all();
        run_vec('{"win_enter_ign", B_ENTER, 4'b1000, 4'b1000, 4'b0010, 16'hFFFF, sol_vals, 1'b0, 1'b1, 0});
        run_vec('{"win_clear_ign", B_CLEAR, 4'b1000, 4'b1000, 4'b0010, 16'hFFFF, sol_vals, 1'b0, 1'b1, 0});
        run_vec('{"win_new_game",  B_NEW,   4'b1000, 4'b1000, 4'b0001, 16'h7FFF, sol_vals, 1'b0, 1'b0, 1});

        // Reset during CHECK cycle 2 aborts the move.
        row_sel = 4'b1000; col_sel = 4'b1000; num_in = 4'b0001;
        repeat (2) @(negedge clk);
        enter = 1'b1;
        wait_busy("abort");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort cell_vals", cell_vals, 32'h0);
        check("abort filled", 32'(filled), 32'h0);
        check("abort fixed_mask", 32'(fixed_mask), 32'h0);
        check("abort cursor", 32'({cursor_row, cursor_col}), 32'h0);
        check("abort flags", 32'({error_flag, win_flag, busy}), 32'h0);
        enter = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        nb = 0;
        repeat (12) begin @(negedge clk); nb += int'(busy); end
        check("abort no_resume", 32'(nb), 32'h0);
        check("abort no_write", 32'(filled), 32'h0);

        // Simultaneous enter + new_game: only the load happens.
        puzzle_mask = 16'h8421; puzzle_vals = 32'h0030_0C00;
        row_sel = 4'b0001; col_sel = 4'b0010; num_in = 4'b0010;
        repeat (2) @(negedge clk);
        enter = 1'b1; new_game = 1'b1;
        wait_busy("both");
        nb = 0;
        repeat (12) begin @(negedge clk); nb += int'(busy); end
        check("both busy_after_load", 32'(nb), 32'h0);
        release_all();
        check("both filled", 32'(filled), 32'h8421);
        check("both cell_vals", cell_vals, 32'h0030_0C00);
        check("both error_flag", 32'(error_flag), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sudoku_move_ctrl.md
# sudoku_move_ctrl

Move sequencer for the 4x4 Sudoku game core, running on the 100 MHz system clock. It debounces the enter/clear/new_game buttons and decodes the one-hot row/column/digit switches into a cursor and digit. It loads puzzles, validates each move against its row, column and 2x2 box over a fixed multi-cycle scan, then commits or rejects the move. It drives the grid state, error flag and win flag consumed by the VGA renderer.

## Interface
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must be stable before it is accepted (10 ms at 100 MHz).
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- enter, clear, new_game  in  1 each  raw button inputs, active-high.
- row_sel, col_sel  in  4  one-hot switches; bit k selects row/column k.
- num_in  in  4  one-hot digit switch; bit k selects digit k+1.
- puzzle_vals  in  32  puzzle digits; cell i = row*4+col, bits [2i+1:2i] = digit-1.
- puzzle_mask  in  16  puzzle given-cells; bit i = cell i is pre-filled.
- cell_vals  out  32  current digits, same encoding as puzzle_vals.
- filled  out  16  bit i = cell i holds a digit.
- fixed_mask  out  16  bit i = cell i is a given and may not be changed.
- cursor_row, cursor_col  out  2 each  current cursor cell.
- error_flag  out  1  last operation was rejected.
- win_flag  out  1  all 16 cells filled.
- busy  out  1  FSM not in IDLE.

## Operation
- Buttons: 2-FF synchronizer → stable-level debounce counter (DEBOUNCE_CYCLES) → rising-edge detect → one-cycle pulse. Pulses arriving while busy=1 are dropped, not queued.
- Simultaneous pulses: new_game > enter > clear.
- Cursor: updated in IDLE only, when row_sel and col_sel are both exactly one-hot. Otherwise the cursor holds its value and sel_valid=0.
- Digit: valid only if num_in is exactly one-hot.
- FSM states: IDLE, LOAD, CHECK, COMMIT, WINCHK.
- IDLE + new_game → LOAD.
  - LOAD (1 cycle): cell_vals←puzzle_vals, filled←puzzle_mask, fixed_mask←puzzle_mask, error_flag←0, win_flag←0. Then → IDLE.
- IDLE + enter with win_flag=1: ignored.
- IDLE + enter with sel_valid=0, digit invalid, or fixed_mask[i]=1: error_flag←1, stay in IDLE, no write.
- IDLE + enter otherwise: latch target (r,c,d), clear conflict accumulator, → CHECK.
  - CHECK lasts 4 cycles, k=0..3. In cycle k, compare three peer cells against d: (r,k), (k,c), and box cell ({r[1],k[1]},{c[1],k[0]}).
  - A peer conflicts if it is filled, holds d, and is not the target cell itself. Conflicts are OR-accumulated.
  - CHECK → COMMIT after k=3.
  - COMMIT (1 cycle): on conflict, error_flag←1 and the cell is unchanged. Otherwise cell_vals[i]←d-1, filled[i]←1, error_flag←0. Overwriting a non-fixed filled cell is allowed. Then → WINCHK.
  - WINCHK (1 cycle): win_flag←&filled. Then → IDLE.
- IDLE + clear with win_flag=1: ignored.
- IDLE + clear with sel_valid=0 or fixed_mask[i]=1: error_flag←1.
- IDLE + clear otherwise: filled[i]←0, error_flag←0. cell_vals is unchanged.
- A filled cell whose given value violates the rules is never re-checked; only moves are validated.

## Timing
- Reset (asynchronous assert): state=IDLE. All outputs 0: cell_vals, filled, fixed_mask, cursor, error_flag, win_flag, busy. Debounce counters and synchronizers are also cleared.
- Reset asserted mid-CHECK or mid-COMMIT aborts the move with no write.
- Button latency: raw edge → pulse after 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- Enter sequence, with the pulse in cycle 0:
  - busy=1 in cycles 1–6.
  - CHECK occupies cycles 1–4; COMMIT is cycle 5; WINCHK is cycle 6.
  - cell_vals/filled/error_flag are visible from cycle 6.
  - win_flag is visible from cycle 7.
  - A new pulse is accepted from cycle 7.
- new_game pulse in cycle 0: busy=1 in cycle 1; loaded state visible from cycle 2.
- clear, rejected enter, and rejected clear: outputs visible in cycle 1; busy stays 0.
- Cursor changes in IDLE are visible one cycle after the switches become valid.

## Test plan
Benches use DEBOUNCE_CYCLES=4.

- Reset, then new_game with puzzle_mask=16'h8421 and a valid puzzle_vals → fixed_mask=filled=16'h8421, error_flag=0, win_flag=0, busy high for exactly 1 cycle.
- Cursor (0,1), digit 2, no conflicts, enter → after 7 cycles filled[1]=1, cell_vals[3:2]=2'b01, error_flag=0. A bounce of less than 4 cycles on enter produces no move.
- Row, column and box conflict cases, each with cell (0,0) fixed to 1: enter digit 1 at (0,3) → error_flag=1; at (3,0) → error_flag=1; at (1,1) → error_flag=1. filled is unchanged in all three cases.
- Enter or clear on a fixed cell, or with row_sel=4'b0011 → error_flag=1 within 1 cycle, no state change. A subsequent valid clear → error_flag=0.
- Fill the last empty cell validly → win_flag=1 at cycle 7. A further enter is ignored. new_game clears win_flag.
- Assert reset during CHECK cycle 2 → all outputs 0 and no write. A simultaneous enter+new_game pulse → LOAD only.
